// File: rtl/clk_div_scheduler.sv
// Multi-channel programmable clock-enable divider with boundary-aligned ratio updates.
// Optional square-wave clk_level outputs are built when DIV_DUTY_EN is defined.
module clk_div_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_en,
  output logic [NUM_CH-1:0] clk_flag,
  output logic [NUM_CH-1:0] ch_active,
  output logic [NUM_CH-1:0] upd_pend
`ifdef DIV_DUTY_EN
  ,
  output logic [NUM_CH-1:0] clk_level
`endif
);

  // state      | meaning
  // S_IDLE     | stopped, cnt held at 0, no pulses
  // S_RUN      | dividing by div, no update waiting
  // S_RUN_PEND | dividing by div, accepted update waits for the boundary
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_RUN_PEND = 2'd2
  } state_t;

  logic [NUM_CH-1:0] ch_sel;
  logic              cfg_go;

  // Out-of-range channel codes match no channel, so they read ready and are dropped.
  assign cfg_ready = ~reset & ~|(ch_sel & upd_pend);
  assign cfg_go    = cfg_en & (cfg_div != '0);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] div, div_nxt;
    logic [CNT_W-1:0] pdiv, pdiv_nxt;
    logic             pgo, pgo_nxt;
    logic             flag, flag_nxt;
    logic             level, level_nxt;
    logic             acc, boundary, run_nxt;

    assign ch_sel[i] = (cfg_ch == CH_W'(i));
    assign acc       = cfg_valid & cfg_ready & ch_sel[i];
    assign boundary  = (cnt == div - CNT_W'(1));

    always_ff @(posedge clk_in) begin
      if (reset) begin
        state <= S_IDLE;
        cnt   <= '0;
        div   <= '0;
        pdiv  <= '0;
        pgo   <= 1'b0;
        flag  <= 1'b0;
        level <= 1'b0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        div   <= div_nxt;
        pdiv  <= pdiv_nxt;
        pgo   <= pgo_nxt;
        flag  <= flag_nxt;
        level <= level_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      div_nxt   = div;
      pdiv_nxt  = pdiv;
      pgo_nxt   = pgo;
      unique case (state)
        S_IDLE: begin
          cnt_nxt = '0;
          if (acc && cfg_go) begin
            state_nxt = S_RUN;
            div_nxt   = cfg_div;
          end
        end
        S_RUN: begin
          if (boundary) begin
            cnt_nxt = '0;
            // An accept on the boundary cycle lands right after the old period ends.
            if (acc) begin
              if (cfg_go) div_nxt = cfg_div;
              else        state_nxt = S_IDLE;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
            if (acc) begin
              state_nxt = S_RUN_PEND;
              pdiv_nxt  = cfg_div;
              pgo_nxt   = cfg_go;
            end
          end
        end
        S_RUN_PEND: begin
          if (boundary) begin
            cnt_nxt = '0;
            if (pgo) begin
              state_nxt = S_RUN;
              div_nxt   = pdiv;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase

      run_nxt   = (state_nxt != S_IDLE);
      flag_nxt  = run_nxt && (cnt_nxt == div_nxt - CNT_W'(1));
      level_nxt = run_nxt && ((div_nxt == CNT_W'(1)) || (cnt_nxt < (div_nxt >> 1)));
    end

    always_comb begin
      ch_active[i] = (state != S_IDLE);
      upd_pend[i]  = (state == S_RUN_PEND);
      clk_flag[i]  = flag;
    end

`ifdef DIV_DUTY_EN
    assign clk_level[i] = level;
`endif
  end

endmodule

// File: tb/tb_clk_div_scheduler.sv
// Directed self-checking bench for clk_div_scheduler (NUM_CH=4, CNT_W=8).
// clk_level checks are compiled in only when DIV_DUTY_EN is defined.
module tb_clk_div_scheduler;

  logic       clk_in;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_en;
  logic [3:0] clk_flag;
  logic [3:0] ch_active;
  logic [3:0] upd_pend;
`ifdef DIV_DUTY_EN
  logic [3:0] clk_level;
`endif

  int vectors = 0;
  int miscompares = 0;

  clk_div_scheduler #(.NUM_CH(4), .CNT_W(8)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
    .clk_flag  (clk_flag),
    .ch_active (ch_active),
    .upd_pend  (upd_pend)
`ifdef DIV_DUTY_EN
    ,
    .clk_level (clk_level)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one config beat for one cycle; the channel must be ready for it.
  task automatic cfg(input int ch, input int dv, input bit en);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = 8'(dv);
    cfg_en    = en;
    #1;
    chk("cfg_ready_at_accept", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
  endtask

  // Cycle k=0 is the current cycle; pulses expected at first, first+per, ...
  task automatic expect_flags(input string tag, input int ch, input int ncyc,
                              input int first, input int per);
    for (int k = 0; k < ncyc; k++) begin
      chk(tag, 32'(clk_flag[ch]), 32'((k >= first) && (((k - first) % per) == 0)));
      tick();
    end
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_div   = 8'd0;
    cfg_en    = 1'b0;

    // 1: reset state, then ch0 N=6
    tick();
    tick();
    chk("ready_in_reset", 32'(cfg_ready), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_flag", 32'(clk_flag), 32'd0);
    chk("rst_active", 32'(ch_active), 32'd0);
    chk("rst_pend", 32'(upd_pend), 32'd0);
    chk("ready_after_reset", 32'(cfg_ready), 32'd1);
    cfg(0, 6, 1'b1);
    chk("t1_active", 32'(ch_active), 32'b0001);
    expect_flags("t1_flag0", 0, 13, 5, 6);

    // 2: ch1 N=5, mid-period change to N=3
    cfg(1, 5, 1'b1);
    expect_flags("t2_flag1_a", 1, 2, 4, 5);
    cfg(1, 3, 1'b1);
    chk("t2_pend_set", 32'(upd_pend[1]), 32'd1);
    cfg_valid = 1'b1;
    cfg_ch    = 2'd1;
    cfg_div   = 8'd2;
    #1;
    chk("t2_ready_ch1_pending", 32'(cfg_ready), 32'd0);
    cfg_ch = 2'd2;
    #1;
    chk("t2_ready_ch2_free", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b0;
    expect_flags("t2_flag1_b", 1, 2, 1, 3);
    chk("t2_pend_clear", 32'(upd_pend[1]), 32'd0);
    expect_flags("t2_flag1_c", 1, 6, 2, 3);

    // 3: ch2 N=6, update to N=4 accepted on the boundary cycle
    cfg(2, 6, 1'b1);
    expect_flags("t3_flag2_a", 2, 5, 5, 6);
    chk("t3_boundary_flag", 32'(clk_flag[2]), 32'd1);
    cfg(2, 4, 1'b1);
    chk("t3_no_pend", 32'(upd_pend[2]), 32'd0);
    expect_flags("t3_flag2_b", 2, 9, 3, 4);

    // 4: ch0 N=1, then stop via en=0 and via div=0
    cfg(0, 1, 1'b1);
    n = 0;
    while (upd_pend[0] && n < 8) begin
      tick();
      n++;
    end
    chk("t4_pend_bounded", 32'(n < 8), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("t4_n1_flag", 32'(clk_flag[0]), 32'd1);
      tick();
    end
    cfg(0, 5, 1'b0);
    chk("t4_en0_flag", 32'(clk_flag[0]), 32'd0);
    chk("t4_en0_active", 32'(ch_active[0]), 32'd0);
    cfg(0, 1, 1'b1);
    chk("t4_restart_flag", 32'(clk_flag[0]), 32'd1);
    chk("t4_restart_active", 32'(ch_active[0]), 32'd1);
    cfg(0, 0, 1'b1);
    chk("t4_div0_flag", 32'(clk_flag[0]), 32'd0);
    chk("t4_div0_active", 32'(ch_active[0]), 32'd0);
    chk("t4_div0_pend", 32'(upd_pend[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_stays_idle", 32'(clk_flag[0]), 32'd0);
    end

    // 5: reset with ch3 pending
    cfg(3, 3, 1'b1);
    cfg(3, 7, 1'b1);
    chk("t5_pend_set", 32'(upd_pend[3]), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_ready_in_reset", 32'(cfg_ready), 32'd0);
    tick();
    chk("t5_flag", 32'(clk_flag), 32'd0);
    chk("t5_active", 32'(ch_active), 32'd0);
    chk("t5_pend", 32'(upd_pend), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t5_quiet_flag", 32'(clk_flag), 32'd0);
      chk("t5_quiet_active", 32'(ch_active), 32'd0);
    end

`ifdef DIV_DUTY_EN
    // 6: duty-cycle outputs, N=5 -> 2/3, N=6 -> 3/3
    chk("t6_idle_level", 32'(clk_level), 32'd0);
    cfg(1, 5, 1'b1);
    for (int k = 0; k < 10; k++) begin
      chk("t6_level_n5", 32'(clk_level[1]), 32'((k % 5) < 2));
      tick();
    end
    cfg(2, 6, 1'b1);
    for (int k = 0; k < 12; k++) begin
      chk("t6_level_n6", 32'(clk_level[2]), 32'((k % 6) < 3));
      tick();
    end
    chk("t6_idle_ch3_level", 32'(clk_level[3]), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
